// File: rtl/spi_dac_pkg.sv
// Shared types and idle levels for the multi-lane SPI DAC engine.
// Optional feature macro: SPI_DAC_ARRAY_READBACK_EN (per-lane Miso capture).
package spi_dac_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;

  localparam logic SCK_IDLE  = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;
  localparam logic NCS_IDLE  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cntW(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_dac_array_if.sv
// Register-space and DAC-pin bundle for spi_dac_array.
interface spi_dac_array_if
  import spi_dac_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int WORD_W = 32,
  parameter int CS_W   = 4
);
  localparam int CSEL_W = cntW(CS_W);

  logic                     WriteDac;
  logic [NUM_CH-1:0]        ChMask;
  logic [CSEL_W-1:0]        CsSel;
  logic [NUM_CH*WORD_W-1:0] DataToMosi;
  logic [NUM_CH-1:0]        Miso;
  logic [NUM_CH-1:0]        Sck;
  logic [NUM_CH-1:0]        Mosi;
  logic [NUM_CH*CS_W-1:0]   nCs;
  logic                     Busy;
  logic                     XferComplete;
  logic [NUM_CH*WORD_W-1:0] DataFromMiso;

  modport slave (
    input  WriteDac, ChMask, CsSel, DataToMosi, Miso,
    output Sck, Mosi, nCs, Busy, XferComplete, DataFromMiso
  );
  modport master (
    output WriteDac, ChMask, CsSel, DataToMosi, Miso,
    input  Sck, Mosi, nCs, Busy, XferComplete, DataFromMiso
  );
endinterface

// File: rtl/spi_dac_lane.sv
// One SPI DAC lane: tx shifter, optional rx capture, pin gating by lane mask.
// SPI_DAC_ARRAY_READBACK_EN enables the rx shifter; otherwise readback is all-ones.
module spi_dac_lane
  import spi_dac_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CS_W   = 4,
  parameter int CSEL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              sample,
  input  logic              done,
  input  logic              csActive,
  input  logic              sckShared,
  input  logic              en,
  input  logic [CSEL_W-1:0] csSel,
  input  logic [WORD_W-1:0] txData,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic [CS_W-1:0]   nCs,
  output logic [WORD_W-1:0] dataOut
);
  logic [WORD_W-1:0] txSr;
  logic              active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        txSr <= '0;
    else if (load)  txSr <= txData;
    else if (shift) txSr <= txSr << 1;
  end

  assign active = csActive & en;
  assign sck    = en ? sckShared : SCK_IDLE;
  assign mosi   = active ? txSr[WORD_W-1] : MOSI_IDLE;

  // Out-of-range select matches no line, so the frame runs with no chip selected.
  always_comb begin
    nCs = {CS_W{NCS_IDLE}};
    for (int j = 0; j < CS_W; j++)
      if (active && (int'(csSel) == j)) nCs[j] = ~NCS_IDLE;
  end

`ifdef SPI_DAC_ARRAY_READBACK_EN
  logic [WORD_W-1:0] rxSr, rxQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxSr <= '0;
      rxQ  <= '0;
    end else begin
      if (sample)     rxSr <= {rxSr[WORD_W-2:0], miso};
      if (done && en) rxQ  <= rxSr;
    end
  end

  assign dataOut = rxQ;
`else
  logic unusedRx;
  assign unusedRx = ^{miso, sample, done};
  assign dataOut  = '1;
`endif
endmodule

// File: rtl/spi_dac_array.sv
// Shared SPI sequencer driving NUM_CH lockstep DAC lanes (CPOL=1, MSB first).
// SPI_DAC_ARRAY_READBACK_EN enables per-lane Miso readback into DataFromMiso.
module spi_dac_array #(
  parameter int NUM_CH   = 6,
  parameter int WORD_W   = 32,
  parameter int CS_W     = 4,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_dac_array_if.slave bus
);
  import spi_dac_pkg::*;

  localparam int CSEL_W = cntW(CS_W);
  localparam int DIV_W  = cntW(CLK_DIV);
  localparam int BIT_W  = cntW(WORD_W);
  localparam int PH_W   = cntW((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);

  state_t            state, stateNx;
  logic [DIV_W-1:0]  divCnt, divNx;
  logic              half, halfNx;   // 0: Sck-low half, 1: Sck-high half
  logic [BIT_W-1:0]  bitCnt, bitNx;
  logic [PH_W-1:0]   phCnt, phNx;
  logic [NUM_CH-1:0] maskQ;
  logic [CSEL_W-1:0] csSelQ;
  logic              start, divEnd, load, shift, sample, csActive, sckShared, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      divCnt <= '0;
      half   <= 1'b0;
      bitCnt <= '0;
      phCnt  <= '0;
      maskQ  <= '0;
      csSelQ <= '0;
    end else begin
      state  <= stateNx;
      divCnt <= divNx;
      half   <= halfNx;
      bitCnt <= bitNx;
      phCnt  <= phNx;
      if (start) begin
        maskQ  <= bus.ChMask;
        csSelQ <= bus.CsSel;
      end
    end
  end

  assign start  = (state == IDLE) && bus.WriteDac;
  assign divEnd = (divCnt == DIV_W'(CLK_DIV - 1));

  // CS_SETUP/CS_HOLD are also timing parameters here, so those states are package-qualified.
  always_comb begin
    stateNx = state;
    divNx   = divCnt;
    halfNx  = half;
    bitNx   = bitCnt;
    phNx    = phCnt;
    case (state)
      IDLE: if (bus.WriteDac) begin
        stateNx = spi_dac_pkg::CS_SETUP;
        phNx    = '0;
      end
      spi_dac_pkg::CS_SETUP: begin
        if (phCnt == PH_W'(CS_SETUP - 1)) begin
          stateNx = SHIFT;
          divNx   = '0;
          halfNx  = 1'b0;
          bitNx   = BIT_W'(WORD_W - 1);
        end else phNx = phCnt + 1'b1;
      end
      SHIFT: begin
        if (divEnd) begin
          divNx  = '0;
          halfNx = ~half;
          if (half) begin
            if (bitCnt == '0) begin
              stateNx = spi_dac_pkg::CS_HOLD;
              phNx    = '0;
            end else bitNx = bitCnt - 1'b1;
          end
        end else divNx = divCnt + 1'b1;
      end
      spi_dac_pkg::CS_HOLD: begin
        if (phCnt == PH_W'(CS_HOLD - 1)) stateNx = DONE;
        else                              phNx    = phCnt + 1'b1;
      end
      DONE:    stateNx = IDLE;
      default: stateNx = IDLE;
    endcase
  end

  // Bit WORD_W-1 is presented during setup, so the first falling edge does not shift.
  assign load      = start;
  assign shift     = (state == SHIFT) && half && divEnd && (bitCnt != '0);
  assign sample    = (state == SHIFT) && !half && divEnd;
  assign done      = (state == DONE);
  assign csActive  = (state == spi_dac_pkg::CS_SETUP) || (state == SHIFT) ||
                     (state == spi_dac_pkg::CS_HOLD);
  assign sckShared = !((state == SHIFT) && !half);

  logic [NUM_CH-1:0]             sck, mosi;
  logic [NUM_CH-1:0][CS_W-1:0]   nCs;
  logic [NUM_CH-1:0][WORD_W-1:0] rdData;

  for (genvar i = 0; i < NUM_CH; i++) begin : gLane
    spi_dac_lane #(.WORD_W(WORD_W), .CS_W(CS_W), .CSEL_W(CSEL_W)) uLane (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift    (shift),
      .sample   (sample),
      .done     (done),
      .csActive (csActive),
      .sckShared(sckShared),
      .en       (maskQ[i]),
      .csSel    (csSelQ),
      .txData   (bus.DataToMosi[i*WORD_W +: WORD_W]),
      .miso     (bus.Miso[i]),
      .sck      (sck[i]),
      .mosi     (mosi[i]),
      .nCs      (nCs[i]),
      .dataOut  (rdData[i])
    );
  end

  assign bus.Sck          = sck;
  assign bus.Mosi         = mosi;
  assign bus.nCs          = nCs;
  assign bus.DataFromMiso = rdData;
  assign bus.Busy         = (state != IDLE);
  assign bus.XferComplete = done;
endmodule

// File: tb/tb_spi_dac_array.sv
// Directed bench for spi_dac_array: reset, single/masked frames, busy reject, mid-frame reset, readback.
module tb_spi_dac_array;
  localparam int NCH = 6, WW = 32, CW = 4;
`ifdef SPI_DAC_ARRAY_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_dac_array_if #(.NUM_CH(NCH), .WORD_W(WW), .CS_W(CW)) bus();

  spi_dac_array #(.NUM_CH(NCH), .WORD_W(WW), .CS_W(CW), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [NCH-1:0][WW-1:0] txd;
  logic                   misoZero;
  assign bus.DataToMosi = txd;
  assign bus.Miso       = misoZero ? '0 : bus.Mosi;

  int nCmp = 0, nErr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int l);
    return bus.DataFromMiso[l*32 +: 32];
  endfunction

  function automatic logic [31:0] rbExp(input logic [31:0] v);
    return RB ? v : 32'hFFFF_FFFF;
  endfunction

  int                lat, nPulse;
  logic [NCH-1:0][31:0] seen;
  logic [NCH-1:0]    pinLow;
  logic [23:0]       ncsMid;
  logic              busy1;

  task automatic idleChk(input string tag);
    chk({tag, "Sck"},  64'(bus.Sck), 64'h3F);
    chk({tag, "Mosi"}, 64'(bus.Mosi), 64'h3F);
    chk({tag, "Ncs"},  64'(bus.nCs), 64'hFF_FFFF);
    chk({tag, "Busy"}, 64'(bus.Busy), 64'h0);
    chk({tag, "Xfer"}, 64'(bus.XferComplete), 64'h0);
  endtask

  // n counts clk rising edges since the start strobe was sampled.
  task automatic frame(input logic [5:0] mask, input logic [1:0] cs, input int injectAt, input int rstAt);
    logic [5:0] prevSck, rise;
    lat = 0; nPulse = 0; seen = '0; pinLow = '0; ncsMid = '1; busy1 = 1'b0;
    @(negedge clk);
    prevSck      = bus.Sck;
    bus.WriteDac = 1'b1;
    bus.ChMask   = mask;
    bus.CsSel    = cs;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      bus.WriteDac = (n == injectAt);
      if (n == injectAt) txd[0] = 32'hDEAD_BEEF;
      if (n == 1)   busy1  = bus.Busy;
      if (n == 100) ncsMid = bus.nCs;
      rise    = ~prevSck & bus.Sck;
      prevSck = bus.Sck;
      for (int l = 0; l < NCH; l++) begin
        if (rise[l]) seen[l] = {seen[l][30:0], bus.Mosi[l]};
        if (!bus.Sck[l] || !bus.Mosi[l] || bus.nCs[l*4 +: 4] != 4'hF) pinLow[l] = 1'b1;
      end
      if (bus.XferComplete) begin
        nPulse++;
        if (lat == 0) lat = n;
      end
      if (n == rstAt) begin
        chk("preRstSck", 64'(bus.Sck[0]), 64'h0);
        rst = 1'b1;
        #1;
        idleChk("midRst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      if (lat != 0 && n == lat + 5) break;
    end
    bus.WriteDac = 1'b0;
  endtask

  initial begin
    bus.WriteDac = 1'b0;
    bus.ChMask   = '0;
    bus.CsSel    = '0;
    misoZero     = 1'b0;
    txd          = '0;

    repeat (3) @(negedge clk);
    idleChk("rst");
    for (int l = 0; l < NCH; l++) chk("rstRd", 64'(rd(l)), 64'(rbExp(32'h0)));
    rst = 1'b0;

    // Single lane A, chip select 2, Miso looped back
    txd[0] = 32'hA5A5_0F0F;
    frame(6'h01, 2'd2, 0, 0);
    chk("oneLat",   64'(lat), 64'd261);
    chk("onePulse", 64'(nPulse), 64'd1);
    chk("oneBusy",  64'(busy1), 64'h1);
    chk("oneMosi",  64'(seen[0]), 64'hA5A5_0F0F);
    chk("oneNcs",   64'(ncsMid), 64'hFF_FFFB);
    chk("onePins",  64'(pinLow), 64'h01);
    chk("oneRd",    64'(rd(0)), 64'(rbExp(32'hA5A5_0F0F)));
    chk("oneIdle",  64'(bus.Busy), 64'h0);

    // Lanes B, D, F only
    txd = {32'hF0F0_1234, 32'h1357_9BDF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0BAD_CAFE, 32'h5555_AAAA};
    frame(6'h2A, 2'd0, 0, 0);
    chk("mskLat",  64'(lat), 64'd261);
    chk("mskPins", 64'(pinLow), 64'h2A);
    chk("mskNcs",  64'(ncsMid), 64'hEF_EFEF);
    chk("mskB",    64'(seen[1]), 64'h0BAD_CAFE);
    chk("mskD",    64'(seen[3]), 64'h8000_0001);
    chk("mskF",    64'(seen[5]), 64'hF0F0_1234);
    chk("mskRdA",  64'(rd(0)), 64'(rbExp(32'hA5A5_0F0F)));
    chk("mskRdB",  64'(rd(1)), 64'(rbExp(32'h0BAD_CAFE)));
    chk("mskRdC",  64'(rd(2)), 64'(rbExp(32'h0)));
    chk("mskRdD",  64'(rd(3)), 64'(rbExp(32'h8000_0001)));
    chk("mskRdE",  64'(rd(4)), 64'(rbExp(32'h0)));
    chk("mskRdF",  64'(rd(5)), 64'(rbExp(32'hF0F0_1234)));

    // Second start 10 cycles in is dropped
    txd[0] = 32'h1234_5678;
    frame(6'h01, 2'd1, 10, 0);
    chk("bsyLat",   64'(lat), 64'd261);
    chk("bsyPulse", 64'(nPulse), 64'd1);
    chk("bsyMosi",  64'(seen[0]), 64'h1234_5678);
    chk("bsyRd",    64'(rd(0)), 64'(rbExp(32'h1234_5678)));

    // Start during the DONE cycle is dropped
    txd[0] = 32'h0F1E_2D3C;
    frame(6'h01, 2'd3, 261, 0);
    chk("dnPulse", 64'(nPulse), 64'd1);
    chk("dnBusy",  64'(bus.Busy), 64'h0);
    chk("dnMosi",  64'(seen[0]), 64'h0F1E_2D3C);

    // Empty mask still runs the timing
    frame(6'h00, 2'd0, 0, 0);
    chk("zLat",   64'(lat), 64'd261);
    chk("zPulse", 64'(nPulse), 64'd1);
    chk("zPins",  64'(pinLow), 64'h00);

    // Reset during bit 15 of the shift phase
    txd[0] = 32'hFFFF_0000;
    frame(6'h01, 2'd0, 0, 132);
    chk("rsPulse", 64'(nPulse), 64'd0);
    chk("rsRd",    64'(rd(0)), 64'(rbExp(32'h0)));

    // Clean all-lane frame after the abort
    txd = {32'h1111_2222, 32'h2468_ACE0, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA};
    frame(6'h3F, 2'd3, 0, 0);
    chk("clnLat",   64'(lat), 64'd261);
    chk("clnPulse", 64'(nPulse), 64'd1);
    chk("clnPins",  64'(pinLow), 64'h3F);
    chk("clnNcs",   64'(ncsMid), 64'h77_7777);
    chk("clnMosiE", 64'(seen[4]), 64'h2468_ACE0);
    chk("clnRdE",   64'(rd(4)), 64'(rbExp(32'h2468_ACE0)));

    // Miso held low
    misoZero = 1'b1;
    frame(6'h3F, 2'd1, 0, 0);
    for (int l = 0; l < NCH; l++) chk("m0Rd", 64'(rd(l)), 64'(rbExp(32'h0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
